fifo_cache_to_main: RTL and testbench

Write-back buffer on the cache-to-main-memory path, the reverse direction of the main-to-cache fill FIFO. The cache pushes evicted dirty lines (data plus line address), and the memory controller drains them in order through a valid/ready handshake. A store to a line that is already buffered coalesces in place instead of taking a new slot. A combinational snoop port lets the cache miss path fetch a line still sitting in the buffer.

---
 rtl/cache_pkg.sv | 16 +
 rtl/fifo_addr_match.sv | 43 ++++
 rtl/fifo_cache_to_main.sv | 151 +++++++++++++++
 tb/tb_fifo_cache_to_main.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache-to-main write-back path.
package cache_pkg;

  localparam int FIFO_WIDTH_DEF = 512;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef logic [FIFO_WIDTH_DEF-1:0] line_data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] line_addr_t;

  typedef struct packed {
    logic       valid;
    line_addr_t addr;
    line_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/fifo_addr_match.sv
// Age-ordered address lookup over the ring of buffered entries.
// Walks entries from head (oldest) towards tail so that the last hit found
// is the youngest matching entry, which keeps the answer correct across the
// pointer wrap. The head entry can optionally be excluded from matching.
module fifo_addr_match
  import cache_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 valid_vec,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_vec,
  input  logic [PTR_W-1:0]                 head_ptr,
  input  logic [ADDR_WIDTH-1:0]            cmp_addr,
  input  logic                             exclude_head,
  output logic                             hit,
  output logic [PTR_W-1:0]                 match_idx
);

  // Scan oldest to youngest, keeping the last (youngest) match.
  always_comb begin
    logic             hit_v;
    logic [PTR_W-1:0] sel_v;
    logic [PTR_W-1:0] idx_v;
    hit_v = 1'b0;
    sel_v = '0;
    idx_v = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx_v = head_ptr + PTR_W'(a);
      if (valid_vec[idx_v] && (addr_vec[idx_v] == cmp_addr) &&
          !(exclude_head && (a == 0))) begin
        hit_v = 1'b1;
        sel_v = idx_v;
      end else begin
        hit_v = hit_v;
      end
    end
    hit       = hit_v;
    match_idx = sel_v;
  end

endmodule

// File: rtl/fifo_cache_to_main.sv
// Write-back buffer from cache to main memory.
// In-order drain of evicted lines, in-place coalescing of stores to lines that
// are already buffered (never into the head, which memory may be reading),
// and a combinational snoop port for the cache miss path.
module fifo_cache_to_main
  import cache_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [FIFO_WIDTH-1:0]     push_data,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [FIFO_WIDTH-1:0]     pop_data,
  output logic [ADDR_WIDTH-1:0]     pop_addr,
  input  logic [ADDR_WIDTH-1:0]     snoop_addr,
  output logic                      snoop_hit,
  output logic [FIFO_WIDTH-1:0]     snoop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]                 head_r;
  logic [PTR_W-1:0]                 tail_r;
  logic [CNT_W-1:0]                 count_r;
  logic [DEPTH-1:0]                 valid_r;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_r;
  logic [FIFO_WIDTH-1:0]            data_r [DEPTH];

  logic             full_s;
  logic             empty_s;
  logic             co_hit_s;
  logic [PTR_W-1:0] co_idx_s;
  logic             sn_hit_s;
  logic [PTR_W-1:0] sn_idx_s;
  logic             push_fire_s;
  logic             append_s;
  logic             coalesce_s;
  logic             pop_fire_s;

  // Coalesce lookup: never merge into the head entry.
  fifo_addr_match #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .PTR_W     (PTR_W)
  ) u_coalesce_match (
    .valid_vec   (valid_r),
    .addr_vec    (addr_r),
    .head_ptr    (head_r),
    .cmp_addr    (push_addr),
    .exclude_head(1'b1),
    .hit         (co_hit_s),
    .match_idx   (co_idx_s)
  );

  // Snoop lookup: the head is still buffered data, so it is included.
  fifo_addr_match #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .PTR_W     (PTR_W)
  ) u_snoop_match (
    .valid_vec   (valid_r),
    .addr_vec    (addr_r),
    .head_ptr    (head_r),
    .cmp_addr    (snoop_addr),
    .exclude_head(1'b0),
    .hit         (sn_hit_s),
    .match_idx   (sn_idx_s)
  );

  assign full_s      = (count_r == CNT_FULL);
  assign empty_s     = (count_r == '0);
  assign push_ready  = ~full_s | co_hit_s;
  assign push_fire_s = push_valid & push_ready;
  assign append_s    = push_fire_s & ~co_hit_s;
  assign coalesce_s  = push_fire_s & co_hit_s;
  assign pop_valid   = ~empty_s;
  assign pop_fire_s  = pop_valid & pop_ready;

  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Head entry presented to memory; zero when nothing is buffered.
  always_comb begin
    pop_data = '0;
    pop_addr = '0;
    if (!empty_s) begin
      pop_data = data_r[head_r];
      pop_addr = addr_r[head_r];
    end else begin
      pop_data = '0;
      pop_addr = '0;
    end
  end

  // Snoop result: youngest matching line, zero on a miss.
  always_comb begin
    snoop_hit  = sn_hit_s;
    snoop_data = '0;
    if (sn_hit_s) begin
      snoop_data = data_r[sn_idx_s];
    end else begin
      snoop_data = '0;
    end
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
    end else begin
      if (append_s) begin
        tail_r          <= tail_r + PTR_ONE;
        valid_r[tail_r] <= 1'b1;
      end
      if (pop_fire_s) begin
        head_r          <= head_r + PTR_ONE;
        valid_r[head_r] <= 1'b0;
      end
      count_r <= count_r + CNT_W'(append_s) - CNT_W'(pop_fire_s);
    end
  end

  // Entry payload storage: appended lines land at tail, coalesced stores
  // overwrite the matched entry in place. Not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && append_s) begin
      data_r[tail_r] <= push_data;
      addr_r[tail_r] <= push_addr;
    end else if (rst_n && coalesce_s) begin
      data_r[co_idx_s] <= push_data;
    end
  end

endmodule

// File: tb/tb_fifo_cache_to_main.sv
// Directed bench for the write-back buffer with a queue-based reference model.
module tb_fifo_cache_to_main;
  import cache_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = 512;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid;
  logic          push_ready;
  logic [FW-1:0] push_data;
  logic [AW-1:0] push_addr;
  logic          pop_valid;
  logic          pop_ready;
  logic [FW-1:0] pop_data;
  logic [AW-1:0] pop_addr;
  logic [AW-1:0] snoop_addr;
  logic          snoop_hit;
  logic [FW-1:0] snoop_data;
  logic          full;
  logic          empty;
  logic [4:0]    count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_cache_to_main #(
    .DEPTH(DEPTH), .FIFO_WIDTH(FW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_data(push_data), .push_addr(push_addr),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_addr(pop_addr),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
    .full(full), .empty(empty), .count(count)
  );

  function automatic logic [FW-1:0] mk(input int k);
    logic [31:0] w;
    w  = 32'(k) ^ 32'hC0DE_0000;
    mk = {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; checks handshake outputs against the model, then
  // applies the cycle's effect to the model.
  task automatic cycle(input logic pv, input logic [AW-1:0] pa,
                       input logic [FW-1:0] pd, input logic pr);
    int   mi;
    logic exp_rdy;
    logic had;
    ent_t e;
    push_valid = pv; push_addr = pa; push_data = pd; pop_ready = pr;
    #1;
    mi = -1;
    for (int i = 1; i < mq.size(); i++) if (mq[i].addr == pa) mi = i;
    exp_rdy = (mq.size() < DEPTH) || (mi >= 0);
    had     = (mq.size() > 0);
    if (pv) chk("push_ready", push_ready, exp_rdy);
    chk("pop_valid", pop_valid, had);
    if (pr && had) begin
      chk("pop_addr", pop_addr, mq[0].addr);
      chk("pop_data", pop_data, mq[0].data);
    end
    @(posedge clk); #1;
    if (pv && exp_rdy) begin
      if (mi >= 0) mq[mi].data = pd;
      else begin e.addr = pa; e.data = pd; mq.push_back(e); end
    end
    if (pr && had) void'(mq.pop_front());
    push_valid = 1'b0; pop_ready = 1'b0;
  endtask

  task automatic state_chk(input string tag);
    chk({tag, "_count"}, count, mq.size());
    chk({tag, "_empty"}, empty, mq.size() == 0);
    chk({tag, "_full"},  full,  mq.size() == DEPTH);
  endtask

  task automatic snoop_chk(input logic [AW-1:0] a);
    int si;
    snoop_addr = a;
    #1;
    si = -1;
    for (int i = 0; i < mq.size(); i++) if (mq[i].addr == a) si = i;
    chk("snoop_hit",  snoop_hit,  si >= 0);
    chk("snoop_data", snoop_data, (si >= 0) ? mq[si].data : '0);
  endtask

  task automatic drain();
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, '0, 1'b1);
    state_chk("drain");
    chk("drain_pop_data", pop_data, '0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_addr = '0; push_data = '0; snoop_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    // Reset state
    state_chk("rst");
    chk("rst_pop_valid",  pop_valid,  1'b0);
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_pop_data",   pop_data,   '0);
    chk("rst_snoop_hit",  snoop_hit,  1'b0);
    chk("rst_snoop_data", snoop_data, '0);

    // Basic order
    cycle(1'b1, 8'h10, mk(1), 1'b0);
    cycle(1'b1, 8'h20, mk(2), 1'b0);
    cycle(1'b1, 8'h30, mk(3), 1'b0);
    state_chk("basic");
    chk("basic_head_addr", pop_addr, 8'h10);
    chk("basic_head_data", pop_data, mk(1));
    drain();

    // Coalesce, with head exclusion
    cycle(1'b1, 8'h10, mk(11), 1'b0);
    cycle(1'b1, 8'h20, mk(12), 1'b0);
    cycle(1'b1, 8'h30, mk(13), 1'b0);
    cycle(1'b1, 8'h20, mk(14), 1'b0);
    chk("coal_count_mid", count, 5'd3);
    cycle(1'b1, 8'h10, mk(15), 1'b0);
    chk("coal_count_head", count, 5'd4);
    state_chk("coal");
    snoop_chk(8'h20);
    drain();

    // Full, refused push, coalesce while full, full with same-cycle pop
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), mk(100 + i), 1'b0);
    state_chk("full");
    cycle(1'b1, 8'h99, mk(7), 1'b0);
    state_chk("full_refuse");
    cycle(1'b1, 8'h05, mk(55), 1'b0);
    state_chk("full_coal");
    cycle(1'b1, 8'h99, mk(8), 1'b1);
    state_chk("full_pop_nobypass");
    drain();

    // Empty push is not visible the same cycle; duplicates behind the head
    cycle(1'b1, 8'h40, mk(21), 1'b0);
    cycle(1'b1, 8'h40, mk(22), 1'b0);
    state_chk("dup");
    snoop_chk(8'h40);
    snoop_chk(8'h41);
    drain();
    snoop_chk(8'h40);

    // Wrap-around with simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), mk(200 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h80 + i), mk(300 + i), 1'b1);
      if (full || empty || count != 5'd3) chk("wrap_state", {full, empty, count}, {2'b00, 5'd3});
    end
    state_chk("wrap");
    snoop_chk(8'h80 + 8'd39);
    drain();

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), mk(400 + i), 1'b0);
    push_valid = 1'b1; push_addr = 8'hEE; push_data = mk(9); pop_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; push_valid = 1'b0; pop_ready = 1'b0;
    mq.delete();
    #1;
    state_chk("midrst");
    chk("midrst_pop_valid",  pop_valid,  1'b0);
    chk("midrst_push_ready", push_ready, 1'b1);
    for (int i = 0; i < 5; i++) snoop_chk(8'(8'hA0 + i));
    snoop_chk(8'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
